// File: rtl/iob_pfsm_loader.sv
// ---------------------------------------------------------------------------
// iob_pfsm_loader
//
// Purpose:
//   IOb master that programs a PFSM through the PFSM's slave CSR port. It
//   first writes 1 to SOFTRESET, which holds the PFSM in reset. It then takes
//   LUT words one at a time from a valid/ready stream. For each word it writes
//   every DATA_W-wide chunk: first MEM_WORD_SELECT = chunk index, then the
//   chunk data at MEM_BASE + entry*NB. Finally it writes 0 to SOFTRESET.
//   Only writes are issued. The IOb read channel is never used.
//
// Configuration macro:
//   IOB_PFSM_LOADER_TIMEOUT_EN - when defined, a request stalled by
//   iob_ready_i for TIMEOUT_CYC consecutive cycles aborts the load. The abort
//   drops the request, sets the sticky error_o flag and returns to idle
//   without a done_o pulse. When the macro is not defined, the master waits
//   for iob_ready_i indefinitely and error_o is constant 0.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   start_i      start pulse, sampled in idle only
//   n_entries_i  number of LUT entries to load, latched on start and
//                saturated to 2**LUT_ADDR_W
//   lut_valid_i  LUT word stream valid
//   lut_data_i   LUT word {next_state, outputs}
//   lut_ready_o  LUT word accepted when lut_valid_i & lut_ready_o
//   iob_avalid_o IOb request valid
//   iob_addr_o   IOb byte address
//   iob_wdata_o  IOb write data
//   iob_wstrb_o  IOb write strobe: all ones while a request is valid, else 0
//   iob_ready_i  IOb slave ready; a write completes when avalid & ready
//   busy_o       high whenever the loader is not idle
//   done_o       one-cycle pulse when a load completes successfully
//   error_o      sticky abort flag; cleared by start_i or rst_i
// ---------------------------------------------------------------------------
module iob_pfsm_loader #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 12,
    parameter int          LUT_ADDR_W  = 6,
    parameter int          LUT_DATA_W  = 40,
    parameter int unsigned SRST_ADDR   = 32'h0000_0004,
    parameter int unsigned WSEL_ADDR   = 32'h0000_0008,
    parameter int unsigned MEM_BASE    = 32'h0000_0100,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LUT_ADDR_W:0]   n_entries_i,
    input  logic                  lut_valid_i,
    input  logic [LUT_DATA_W-1:0] lut_data_i,
    output logic                  lut_ready_o,
    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int NB      = DATA_W / 8;
    localparam int NB_LOG  = $clog2(NB);
    localparam int NC      = (LUT_DATA_W + DATA_W - 1) / DATA_W;
    localparam int PAD_W   = NC * DATA_W;
    localparam int CHUNK_W = (NC > 1) ? $clog2(NC) : 1;
    localparam int IDX_W   = LUT_ADDR_W + 1;

    // Number of LUT entries in the PFSM (2**LUT_ADDR_W).
    localparam logic [IDX_W-1:0] N_MAX = {1'b1, {LUT_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SRST_SET = 3'd1,
        ST_FETCH    = 3'd2,
        ST_WSEL     = 3'd3,
        ST_WDATA    = 3'd4,
        ST_SRST_CLR = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    n_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CHUNK_W-1:0]  chunk_q;
    logic [PAD_W-1:0]    word_q;
    logic                avalid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                lut_ready_q;
    logic                busy_q;
    logic                done_q;

    logic                wr_done_s;
    logic                abort_s;
    logic                chunk_last_s;
    logic [IDX_W-1:0]    n_sat_d;
    logic [IDX_W-1:0]    idx_inc_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   chunk_data_d;
    logic [DATA_W-1:0]   chunk_next_d;

    assign wr_done_s    = avalid_q & iob_ready_i;
    assign chunk_last_s = (chunk_q == CHUNK_W'(NC - 1));
    assign n_sat_d      = (n_entries_i > N_MAX) ? N_MAX : n_entries_i;
    assign idx_inc_d    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    // The LUT address is scaled to a byte offset and wraps at ADDR_W bits.
    assign mem_addr_d   = ADDR_W'(MEM_BASE) + (ADDR_W'(idx_q) << NB_LOG);
    // word_q is zero-padded, so the top chunk carries zeros above LUT_DATA_W.
    assign chunk_data_d = word_q[int'(chunk_q)*DATA_W +: DATA_W];
    assign chunk_next_d = DATA_W'(chunk_q) + {{(DATA_W-1){1'b0}}, 1'b1};

`ifdef IOB_PFSM_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             error_q;

    // Count consecutive stalled request cycles; an accepted or absent request restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i || !avalid_q || iob_ready_i) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
    end

    // The limit is reached on the cycle whose stall would make the count equal TIMEOUT_CYC.
    assign abort_s = avalid_q & ~iob_ready_i & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Sticky abort flag: set by a timeout, cleared when a new load is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else if (abort_s) begin
            error_q <= 1'b1;
        end else if ((state_q == ST_IDLE) && start_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_q;
        end
    end

    assign error_o = error_q;
`else
    assign abort_s = 1'b0;
    assign error_o = 1'b0;
`endif

    // Loader FSM: sequences the CSR writes and registers every output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= {IDX_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            chunk_q     <= {CHUNK_W{1'b0}};
            word_q      <= {PAD_W{1'b0}};
            avalid_q    <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            lut_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_s) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            chunk_q     <= {CHUNK_W{1'b0}};
            avalid_q    <= 1'b0;
            lut_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i) begin
                        n_q      <= n_sat_d;
                        idx_q    <= {IDX_W{1'b0}};
                        chunk_q  <= {CHUNK_W{1'b0}};
                        busy_q   <= 1'b1;
                        avalid_q <= 1'b1;
                        addr_q   <= ADDR_W'(SRST_ADDR);
                        wdata_q  <= {{(DATA_W-1){1'b0}}, 1'b1};
                        state_q  <= ST_SRST_SET;
                    end
                end
                ST_SRST_SET: begin
                    if (wr_done_s) begin
                        if (n_q != {IDX_W{1'b0}}) begin
                            avalid_q    <= 1'b0;
                            lut_ready_q <= 1'b1;
                            state_q     <= ST_FETCH;
                        end else begin
                            addr_q  <= ADDR_W'(SRST_ADDR);
                            wdata_q <= {DATA_W{1'b0}};
                            state_q <= ST_SRST_CLR;
                        end
                    end
                end
                ST_FETCH: begin
                    // lut_ready_q is high for the whole time the FSM is in this state.
                    if (lut_valid_i) begin
                        word_q      <= PAD_W'(lut_data_i);
                        chunk_q     <= {CHUNK_W{1'b0}};
                        lut_ready_q <= 1'b0;
                        avalid_q    <= 1'b1;
                        addr_q      <= ADDR_W'(WSEL_ADDR);
                        wdata_q     <= {DATA_W{1'b0}};
                        state_q     <= ST_WSEL;
                    end
                end
                ST_WSEL: begin
                    if (wr_done_s) begin
                        addr_q  <= mem_addr_d;
                        wdata_q <= chunk_data_d;
                        state_q <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (wr_done_s) begin
                        if (!chunk_last_s) begin
                            chunk_q <= chunk_q + {{(CHUNK_W-1){1'b0}}, 1'b1};
                            addr_q  <= ADDR_W'(WSEL_ADDR);
                            wdata_q <= chunk_next_d;
                            state_q <= ST_WSEL;
                        end else begin
                            idx_q   <= idx_inc_d;
                            chunk_q <= {CHUNK_W{1'b0}};
                            if (idx_inc_d == n_q) begin
                                addr_q  <= ADDR_W'(SRST_ADDR);
                                wdata_q <= {DATA_W{1'b0}};
                                state_q <= ST_SRST_CLR;
                            end else begin
                                avalid_q    <= 1'b0;
                                lut_ready_q <= 1'b1;
                                state_q     <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_SRST_CLR: begin
                    if (wr_done_s) begin
                        avalid_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    avalid_q    <= 1'b0;
                    lut_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign lut_ready_o  = lut_ready_q;
    assign iob_avalid_o = avalid_q;
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = {NB{avalid_q}};
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_iob_pfsm_loader.sv
// ---------------------------------------------------------------------------
// tb_iob_pfsm_loader
//
// Purpose:
//   Self-checking bench for iob_pfsm_loader with the default parameters
//   (DATA_W=32, LUT_DATA_W=40). Random LUT words, random stream gaps and
//   random IOb ready stalls drive the loader. A model kept in the bench
//   builds the expected list of CSR writes from the word list. The list of
//   writes the loader actually issues is compared against it.
// ---------------------------------------------------------------------------
module tb_iob_pfsm_loader;

    localparam int NCH = (40 + 31) / 32;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [6:0]  n_entries_i;
    logic        lut_valid_i;
    logic [39:0] lut_data_i;
    logic        lut_ready_o;
    logic        iob_avalid_o;
    logic [11:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    iob_pfsm_loader dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .n_entries_i  (n_entries_i),
        .lut_valid_i  (lut_valid_i),
        .lut_data_i   (lut_data_i),
        .lut_ready_o  (lut_ready_o),
        .iob_avalid_o (iob_avalid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_ready_i  (iob_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] src [0:127];
    int src_n, src_rd, gap, gap_max, ready_pct;
    int stab_err, overlap_err, strb_err, done_cnt;
    bit pend, take;
    logic [11:0] p_addr;
    logic [31:0] p_data;

    logic [11:0] obs_a [$];
    logic [31:0] obs_d [$];
    logic [11:0] exp_a [$];
    logic [31:0] exp_d [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. At mid-cycle the task samples the bus and records the
    // write that completes on the coming edge. Shortly after the edge it
    // drives the stream, the slave ready and the start pulse.
    task automatic step();
        @(negedge clk);
        if (iob_avalid_o && iob_ready_i) begin
            obs_a.push_back(iob_addr_o);
            obs_d.push_back(iob_wdata_o);
        end
        if (iob_wstrb_o !== (iob_avalid_o ? 4'hF : 4'h0)) strb_err++;
        if (pend && (!iob_avalid_o || iob_addr_o !== p_addr || iob_wdata_o !== p_data)) stab_err++;
        pend   = iob_avalid_o && !iob_ready_i;
        p_addr = iob_addr_o;
        p_data = iob_wdata_o;
        if (lut_ready_o && (iob_avalid_o || !busy_o)) overlap_err++;
        if (done_o) done_cnt++;
        take = lut_valid_i && lut_ready_o;
        @(posedge clk);
        #2;
        if (take) begin
            src_rd++;
            gap = $urandom_range(0, gap_max);
        end
        if (gap > 0) begin
            lut_valid_i = 1'b0;
            gap--;
        end else if (src_rd < src_n) begin
            lut_valid_i = 1'b1;
            lut_data_i  = src[src_rd][39:0];
        end else begin
            lut_valid_i = 1'b0;
        end
        iob_ready_i = ($urandom_range(0, 99) < ready_pct);
        start_i = 1'b0;
    endtask

    task automatic fill_rand(input int cnt);
        for (int i = 0; i < cnt; i++) src[i] = {24'd0, 8'($urandom), 32'($urandom)};
    endtask

    // Expected write sequence: soft reset set, then for each entry and each
    // 32-bit chunk a word-select write followed by a data write, then soft
    // reset clear.
    task automatic prep_run(input int eff);
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
        stab_err = 0; overlap_err = 0; strb_err = 0; done_cnt = 0; pend = 1'b0;
        src_n = eff; src_rd = 0; gap = 0;
        exp_a.push_back(12'h004); exp_d.push_back(32'd1);
        for (int i = 0; i < eff; i++) begin
            for (int k = 0; k < NCH; k++) begin
                exp_a.push_back(12'h008);
                exp_d.push_back(32'(k));
                exp_a.push_back(12'(32'h100 + 4 * i));
                exp_d.push_back(32'(src[i] >> (32 * k)));
            end
        end
        exp_a.push_back(12'h004); exp_d.push_back(32'd0);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_wr_count"}, 64'(obs_a.size()), 64'(exp_a.size()));
        for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
            chk($sformatf("%s_wr_addr%0d", tag, i), 64'(obs_a[i]), 64'(exp_a[i]));
            chk($sformatf("%s_wr_data%0d", tag, i), 64'(obs_d[i]), 64'(exp_d[i]));
        end
        chk({tag, "_hold_stable"}, 64'(stab_err), 64'd0);
        chk({tag, "_lut_ready_only_fetch"}, 64'(overlap_err), 64'd0);
        chk({tag, "_wstrb"}, 64'(strb_err), 64'd0);
    endtask

    task automatic run_load(input string tag, input int n, input bit mid_start);
        int eff;
        int cyc;
        eff = (n > 64) ? 64 : n;
        prep_run(eff);
        n_entries_i = 7'(n);
        start_i = 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            step();
            cyc++;
            if (mid_start && cyc == 6) begin
                start_i     = 1'b1;
                n_entries_i = 7'd1;
            end
        end
        chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_after_done"}, 64'(busy_o), 64'd0);
        step();
        step();
        chk({tag, "_done_pulse_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_error"}, 64'(error_o), 64'd0);
        chk({tag, "_words_used"}, 64'(src_rd), 64'(eff));
        cmp_writes(tag);
    endtask

    initial begin
        int cyc;
        rst_i = 1'b1; start_i = 1'b0; n_entries_i = 7'd0;
        lut_valid_i = 1'b0; lut_data_i = 40'd0; iob_ready_i = 1'b1;
        ready_pct = 100; gap_max = 0; src_n = 0; src_rd = 0; gap = 0;
        pend = 1'b0; take = 1'b0;
        repeat (3) step();
        chk("rst_avalid", 64'(iob_avalid_o), 64'd0);
        chk("rst_wstrb", 64'(iob_wstrb_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        chk("rst_lut_ready", 64'(lut_ready_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Two 40-bit words, slave always ready, no stream gaps.
        src[0] = 64'h0000_0012_3456_789A;
        src[1] = 64'h0000_00AB_CDEF_0123;
        run_load("two_words", 2, 1'b0);

        // Slave stalls and stream gaps, plus a start pulse while busy.
        fill_rand(5); ready_pct = 60; gap_max = 3;
        run_load("stalls_midstart", 5, 1'b1);

        // Long stream gaps in the fetch state.
        fill_rand(3); ready_pct = 100; gap_max = 6;
        run_load("stream_gaps", 3, 1'b0);

        // Empty load: only the soft reset set and clear writes.
        gap_max = 0;
        run_load("zero_entries", 0, 1'b0);

        // Entry count above the LUT size is saturated to 64.
        fill_rand(64); ready_pct = 80; gap_max = 1;
        run_load("saturate", 100, 1'b0);

        // Reset in the middle of a data write, then a clean reload.
        fill_rand(3); prep_run(3); ready_pct = 100; gap_max = 0;
        n_entries_i = 7'd3; start_i = 1'b1;
        cyc = 0;
        while (!(iob_avalid_o && iob_addr_o == 12'h100) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("rst_mid_reach_wdata", 64'(iob_addr_o), 64'h100);
        rst_i = 1'b1;
        step();
        chk("rst_mid_avalid", 64'(iob_avalid_o), 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0; lut_valid_i = 1'b0;
        step();
        chk("rst_mid_no_request", 64'(iob_avalid_o), 64'd0);
        fill_rand(2);
        run_load("after_reset", 2, 1'b0);

        // Slave never ready on the first word-select write.
        fill_rand(1); prep_run(1); ready_pct = 100; gap_max = 0;
        n_entries_i = 7'd1; start_i = 1'b1;
        cyc = 0;
        while (!(iob_avalid_o && iob_addr_o == 12'h008) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("stall_reach_wsel", 64'(iob_addr_o), 64'h008);
        ready_pct = 0; iob_ready_i = 1'b0;
`ifdef IOB_PFSM_LOADER_TIMEOUT_EN
        repeat (15) step();
        chk("tmo_avalid_before", 64'(iob_avalid_o), 64'd1);
        chk("tmo_error_before", 64'(error_o), 64'd0);
        step();
        chk("tmo_avalid_after", 64'(iob_avalid_o), 64'd0);
        chk("tmo_error_after", 64'(error_o), 64'd1);
        chk("tmo_busy_after", 64'(busy_o), 64'd0);
        ready_pct = 100;
        repeat (3) step();
        chk("tmo_no_done", 64'(done_cnt), 64'd0);
        chk("tmo_error_sticky", 64'(error_o), 64'd1);
        fill_rand(2);
        run_load("after_timeout", 2, 1'b0);
`else
        repeat (40) step();
        chk("wait_avalid", 64'(iob_avalid_o), 64'd1);
        chk("wait_addr", 64'(iob_addr_o), 64'h008);
        chk("wait_error", 64'(error_o), 64'd0);
        chk("wait_busy", 64'(busy_o), 64'd1);
        ready_pct = 100;
        cyc = 0;
        while (done_cnt == 0 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("wait_done", 64'(done_cnt), 64'd1);
        cmp_writes("wait");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
